// File: rtl/whirlpool_state_cipher.sv
// rtl/whirlpool_state_cipher.sv - Whirlpool W-cipher state path, optional feed-forward via WHIRLPOOL_MP_FEEDFORWARD_EN

module WHIRLPOOL_WCIPHER_ROUND (
    input  logic [511:0] state_in,
    output logic [511:0] state_out
);

    logic [7:0] sub  [64];
    logic [7:0] perm [64];

    function automatic logic [3:0] e_box(input logic [3:0] x);
        case (x)
            4'h0: return 4'h1;  4'h1: return 4'hB;  4'h2: return 4'h9;  4'h3: return 4'hC;
            4'h4: return 4'hD;  4'h5: return 4'h6;  4'h6: return 4'hF;  4'h7: return 4'h3;
            4'h8: return 4'hE;  4'h9: return 4'h8;  4'hA: return 4'h7;  4'hB: return 4'h4;
            4'hC: return 4'hA;  4'hD: return 4'h2;  4'hE: return 4'h5;  default: return 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] ei_box(input logic [3:0] x);
        case (x)
            4'h0: return 4'hF;  4'h1: return 4'h0;  4'h2: return 4'hD;  4'h3: return 4'h7;
            4'h4: return 4'hB;  4'h5: return 4'hE;  4'h6: return 4'h5;  4'h7: return 4'hA;
            4'h8: return 4'h9;  4'h9: return 4'h2;  4'hA: return 4'hC;  4'hB: return 4'h1;
            4'hC: return 4'h3;  4'hD: return 4'h4;  4'hE: return 4'h8;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] r_box(input logic [3:0] x);
        case (x)
            4'h0: return 4'h7;  4'h1: return 4'hC;  4'h2: return 4'hB;  4'h3: return 4'hD;
            4'h4: return 4'hE;  4'h5: return 4'h4;  4'h6: return 4'h9;  4'h7: return 4'hF;
            4'h8: return 4'h6;  4'h9: return 4'h3;  4'hA: return 4'h8;  4'hB: return 4'hA;
            4'hC: return 4'h2;  4'hD: return 4'h5;  4'hE: return 4'h1;  default: return 4'h0;
        endcase
    endfunction

    // Whirlpool S-box built from its E / E^-1 / R mini-boxes instead of a 256-entry table
    function automatic logic [7:0] sbox(input logic [7:0] u);
        logic [3:0] e;
        logic [3:0] ei;
        logic [3:0] r;
        e  = e_box(u[7:4]);
        ei = ei_box(u[3:0]);
        r  = r_box(e ^ ei);
        return {e_box(e ^ r), ei_box(ei ^ r)};
    endfunction

    // multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] x2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] x4(input logic [7:0] a);
        return x2(x2(a));
    endfunction

    function automatic logic [7:0] x8(input logic [7:0] a);
        return x2(x2(x2(a)));
    endfunction

    // gamma (S-box), pi (column j rotated down by j), theta (row times circulant 1,1,4,1,8,5,2,9)
    always_comb begin
        state_out = '0;
        for (int n = 0; n < 64; n++) begin
            sub[n] = sbox(state_in[511 - 8*n -: 8]);
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                perm[8*i + j] = sub[8*((i - j + 8) % 8) + j];
            end
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                state_out[511 - 8*(8*i + j) -: 8] =
                      perm[8*i + j]
                    ^ perm[8*i + (j + 7) % 8]
                    ^ x4(perm[8*i + (j + 6) % 8])
                    ^ perm[8*i + (j + 5) % 8]
                    ^ x8(perm[8*i + (j + 4) % 8])
                    ^ x4(perm[8*i + (j + 3) % 8]) ^ perm[8*i + (j + 3) % 8]
                    ^ x2(perm[8*i + (j + 2) % 8])
                    ^ x8(perm[8*i + (j + 1) % 8]) ^ perm[8*i + (j + 1) % 8];
            end
        end
    end

endmodule

module whirlpool_state_cipher #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
    input  logic [511:0] i_key,
    input  logic [511:0] i_data,
    output logic         o_key_init,
    input  logic         i_subkey_valid,
    input  logic [511:0] i_subkey,
    output logic         o_busy,
    output logic         o_valid,
    output logic [511:0] o_data
);

    typedef enum logic [1:0] {IDLE, KINIT, RUN, DONE} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    fsm_t         fsm;
    fsm_t         fsm_next;
    logic [511:0] state_q;
    logic [3:0]   round_cnt;
    logic [511:0] round_out;
    logic [511:0] next_state;
    logic [511:0] result;
    logic         last_strobe;

    WHIRLPOOL_WCIPHER_ROUND u_round (
        .state_in  (state_q),
        .state_out (round_out)
    );

    assign next_state  = round_out ^ i_subkey;
    assign last_strobe = (fsm == RUN) && i_subkey_valid && (round_cnt == LAST_ROUND);

`ifdef WHIRLPOOL_MP_FEEDFORWARD_EN
    logic [511:0] key_hold;
    logic [511:0] data_hold;

    assign result = next_state ^ key_hold ^ data_hold;

    // Miyaguchi-Preneel inputs captured with the accepted start
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            key_hold  <= '0;
            data_hold <= '0;
        end else if (fsm == IDLE && i_start) begin
            key_hold  <= i_key;
            data_hold <= i_data;
        end
    end
`else
    assign result = next_state;
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // next-state decode; init and valid pulses are the KINIT and DONE states themselves
    always_comb begin
        fsm_next   = fsm;
        o_key_init = 1'b0;
        o_valid    = 1'b0;
        case (fsm)
            IDLE:  if (i_start) fsm_next = KINIT;
            KINIT: begin
                o_key_init = 1'b1;
                fsm_next   = RUN;
            end
            RUN:   if (last_strobe) fsm_next = DONE;
            DONE:  begin
                o_valid  = 1'b1;
                fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // cipher state, round counter, busy flag and result register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= '0;
            round_cnt <= '0;
            o_busy    <= 1'b0;
            o_data    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (i_start) begin
                        state_q   <= i_data ^ i_key;
                        round_cnt <= '0;
                        o_busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_subkey_valid) begin
                        state_q <= next_state;
                        if (round_cnt == LAST_ROUND) begin
                            o_data <= result;
                            o_busy <= 1'b0;
                        end else begin
                            round_cnt <= round_cnt + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_whirlpool_state_cipher.sv
// tb/tb_whirlpool_state_cipher.sv - directed bench for whirlpool_state_cipher against the empty-string Whirlpool digest

module tb_whirlpool_state_cipher;

    localparam logic [511:0] HASH_EMPTY = 512'h19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3;
    localparam logic [511:0] MSG_EMPTY  = {8'h80, 504'h0};
    localparam logic [511:0] MSG_OTHER  = {64{8'hA5}};
    localparam logic [63:0]  E_T   = 64'h1B9CD6F3E874A250;
    localparam logic [63:0]  EI_T  = 64'hF0D7BE5A92C13486;
    localparam logic [63:0]  R_T   = 64'h7CBDE49F638A2510;
    localparam logic [63:0]  CIRC  = 64'h0101040108050209;

`ifdef WHIRLPOOL_MP_FEEDFORWARD_EN
    localparam logic [511:0] EXPECT = HASH_EMPTY;
`else
    localparam logic [511:0] EXPECT = HASH_EMPTY ^ MSG_EMPTY;
`endif

    logic         clk;
    logic         rstn;
    logic         start;
    logic [511:0] key;
    logic [511:0] data;
    logic         key_init;
    logic         subkey_valid;
    logic [511:0] subkey;
    logic         busy;
    logic         valid;
    logic [511:0] dout;

    int checks = 0;
    int errors = 0;
    logic [511:0] subkeys [1:10];

    whirlpool_state_cipher #(.NUM_ROUNDS(10)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_start        (start),
        .i_key          (key),
        .i_data         (data),
        .o_key_init     (key_init),
        .i_subkey_valid (subkey_valid),
        .i_subkey       (subkey),
        .o_busy         (busy),
        .o_valid        (valid),
        .o_data         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] u);
        logic [3:0] e, ei, r;
        e  = E_T[63 - 4*u[7:4] -: 4];
        ei = EI_T[63 - 4*u[3:0] -: 4];
        r  = R_T[63 - 4*(e ^ ei) -: 4];
        return {E_T[63 - 4*(e ^ r) -: 4], EI_T[63 - 4*(ei ^ r) -: 4]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [511:0] rnd(input logic [511:0] a);
        logic [7:0] g [8][8];
        logic [7:0] p [8][8];
        logic [7:0] acc;
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                g[i][j] = sb(a[511 - 8*(8*i + j) -: 8]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                p[i][j] = g[(i - j + 8) % 8][j];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                acc = '0;
                for (int k = 0; k < 8; k++)
                    acc = acc ^ gmul(p[i][k], CIRC[63 - 8*((j - k + 8) % 8) -: 8]);
                r[511 - 8*(8*i + j) -: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int gap, input int r);
        repeat (gap) @(negedge clk);
        subkey_valid = 1'b1;
        subkey       = subkeys[r];
        @(negedge clk);
        subkey_valid = 1'b0;
        subkey       = '0;
    endtask

    task automatic do_start(input logic [511:0] d);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [511:0] k;
        logic [511:0] rc;
        k = '0;
        for (int r = 1; r <= 10; r++) begin
            rc = '0;
            for (int j = 0; j < 8; j++) rc[511 - 8*j -: 8] = sb(8'(8*(r - 1) + j));
            k = rnd(k) ^ rc;
            subkeys[r] = k;
        end

        rstn = 1'b0; start = 1'b0; key = '0; data = MSG_EMPTY;
        subkey_valid = 1'b0; subkey = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",     {511'b0, busy},     '0);
        chk("reset_valid",    {511'b0, valid},    '0);
        chk("reset_key_init", {511'b0, key_init}, '0);
        chk("reset_data",     dout,               '0);
        rstn = 1'b1;
        @(negedge clk);

        // spurious strobe while idle
        strobe(0, 1);
        chk("idle_strobe_data", dout, '0);
        chk("idle_strobe_busy", {511'b0, busy}, '0);

        // run 1: nominal producer spacing
        do_start(MSG_EMPTY);
        chk("run1_key_init", {511'b0, key_init}, 512'd1);
        chk("run1_busy_kinit", {511'b0, busy}, 512'd1);
        @(negedge clk);
        chk("run1_key_init_off", {511'b0, key_init}, '0);
        for (int r = 1; r <= 10; r++) begin
            strobe((r == 1) ? 1 : 1, r);
            if (r < 10) begin
                chk("run1_busy", {511'b0, busy}, 512'd1);
                chk("run1_no_valid", {511'b0, valid}, '0);
            end
        end
        chk("run1_valid", {511'b0, valid}, 512'd1);
        chk("run1_busy_low", {511'b0, busy}, '0);
        chk("run1_data", dout, EXPECT);
        @(negedge clk);
        chk("run1_valid_off", {511'b0, valid}, '0);
        chk("run1_data_hold", dout, EXPECT);

        // 11th strobe after completion
        strobe(0, 10);
        chk("extra_strobe_data", dout, EXPECT);
        chk("extra_strobe_valid", {511'b0, valid}, '0);

        // run 2: random gaps, restart attempt with other data mid-run
        do_start(MSG_EMPTY);
        for (int r = 1; r <= 10; r++) begin
            strobe(int'($urandom_range(0, 5)), r);
            if (r == 3) begin
                do_start(MSG_OTHER);
                data = MSG_EMPTY;
                chk("run2_no_reinit", {511'b0, key_init}, '0);
            end
        end
        chk("run2_valid", {511'b0, valid}, 512'd1);
        chk("run2_data", dout, EXPECT);

        // start in the o_valid cycle is ignored, accepted one cycle later
        start = 1'b1;
        @(negedge clk);
        chk("start_in_valid_ignored", {511'b0, key_init}, '0);
        chk("start_in_valid_busy",    {511'b0, busy},     '0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_valid_init", {511'b0, key_init}, 512'd1);
        chk("start_after_valid_busy", {511'b0, busy},     512'd1);

        // run 3: reset after the 5th subkey
        for (int r = 1; r <= 5; r++) strobe(1, r);
        #2 rstn = 1'b0;
        #1;
        chk("abort_busy",     {511'b0, busy},     '0);
        chk("abort_valid",    {511'b0, valid},    '0);
        chk("abort_key_init", {511'b0, key_init}, '0);
        chk("abort_data",     dout,               '0);
        @(negedge clk);
        rstn = 1'b1;
        for (int r = 6; r <= 10; r++) strobe(1, r);
        chk("abort_no_valid", {511'b0, valid}, '0);
        chk("abort_data_zero", dout, '0);

        // run 4: fresh operation after the abort
        do_start(MSG_EMPTY);
        chk("run4_key_init", {511'b0, key_init}, 512'd1);
        for (int r = 1; r <= 10; r++) strobe((r == 1) ? 2 : 1, r);
        chk("run4_valid", {511'b0, valid}, 512'd1);
        chk("run4_data", dout, EXPECT);
        @(negedge clk);
        chk("run4_valid_off", {511'b0, valid}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/whirlpool_state_cipher.md
Name: whirlpool_state_cipher

Overview:
- Consumes the round-subkey stream produced by the Whirlpool key-expansion block (`init` / subkey-valid / 512-bit subkey).
- Applies the 10 Whirlpool W-cipher rounds to a 512-bit message state.
- Instantiates the shared combinational `WHIRLPOOL_WCIPHER_ROUND` for the gamma/pi/theta transform.
- Sits in the PBKDF2-HMAC-Whirlpool compression path, beside the key-expansion block, which it starts and then follows.

Parameters:
- NUM_ROUNDS, 10, number of subkeys consumed before completion (Whirlpool fixes 10; bench only).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_key  input  512  chaining value / cipher key K0; sampled with i_start.
- i_data  input  512  message block; sampled with i_start.
- o_key_init  output  1  one-cycle pulse to key-expansion `init`.
- i_subkey_valid  input  1  one-cycle strobe: i_subkey holds K_r.
- i_subkey  input  512  round subkey K_r, r = 1..NUM_ROUNDS in order.
- o_busy  output  1  high from accepted start until o_valid.
- o_valid  output  1  one-cycle pulse: o_data holds the result.
- o_data  output  512  cipher result (or compression result, see Optional Feature).

Behaviour:
- Reset (async, i_rstn low):
  - All outputs 0: o_key_init, o_busy, o_valid, o_data.
  - State register 0, round counter 0, FSM = IDLE.
  - Takes effect immediately, including mid-operation. No output pulse after release until a new i_start.
- FSM states: IDLE, KINIT, RUN, DONE.
- IDLE:
  - i_start=1 → state <= i_data ^ i_key (initial key addition); latch i_key and i_data into hold registers; round counter <= 0; o_busy <= 1; go KINIT.
  - i_subkey_valid in IDLE is ignored.
- KINIT: o_key_init = 1 for exactly this one cycle; go RUN.
- RUN:
  - Each cycle with i_subkey_valid=1: state <= ROUND(state) ^ i_subkey; counter <= counter + 1.
  - When the counter reaches NUM_ROUNDS-1 on such an edge, go DONE instead.
  - Cycles with i_subkey_valid=0 hold all registers.
  - Subkeys may arrive back-to-back or with any gap. The nominal producer spacing is 2 cycles, with the first strobe 3 cycles after init.
- DONE:
  - o_data <= final state (optionally feed-forwarded); o_valid = 1 for one cycle.
  - o_busy falls in the same cycle o_valid rises.
  - Return to IDLE.
- Latency from the 10th subkey strobe to o_valid: 1 cycle.
- o_data holds its value until the next DONE or reset.
- i_start while busy is ignored. i_start in the same cycle as o_valid is ignored; it is accepted from the following cycle.
- Any i_subkey_valid strobes in DONE, or after completion, are ignored.
- Counter is 4 bits and never wraps beyond NUM_ROUNDS-1.
- All datapath operations are bitwise XOR on 512 bits. Byte 0 is [511:504], matching the key-expansion subkey ordering.
- ROUND() is the same combinational instance used by key expansion, without round constant. No constant is added here; constants come only through i_subkey.

Optional Feature:
- Macro: WHIRLPOOL_MP_FEEDFORWARD_EN.
- Defined: o_data = final_state ^ held i_data ^ held i_key (Miyaguchi-Preneel). o_data is then the new chaining value directly.
- Undefined: o_data = final_state (raw W-cipher output). The hold registers for i_key/i_data are not synthesised.

Test Plan:
- Empty-string hash: i_key=0, i_data=0x80 followed by 504 zero bits (length 0, padded). Paired with the key-expansion block and WHIRLPOOL_MP_FEEDFORWARD_EN defined, o_data must equal 19FA61D75522A4669B44E39C1D2E1726C530232130D407F89AFEE0964997F7A73E83BE698B288FEBCF88E3E03C4F0757EA8964E59B63D93708B138CC42A66EB3.
- Same stimulus without the macro: o_data must equal the expected hash ^ i_data.
- Handshake timing:
  - o_key_init exactly 1 cycle, in the cycle after i_start.
  - o_busy high throughout.
  - o_valid exactly 1 cycle, one cycle after the 10th i_subkey_valid.
- Random-gap subkeys: standalone bench drives 10 model subkeys with gaps 0..5 cycles. o_data must match the reference model. A spurious strobe in IDLE before start, and an 11th strobe after completion, must both leave o_data unchanged.
- i_start pulsed during RUN with different i_data: result unaffected. i_start asserted in the o_valid cycle: ignored. i_start one cycle later: accepted, o_key_init pulses.
- Reset asserted after the 5th subkey: all outputs 0 at once. Release, then start a fresh operation: correct result, with no o_valid from the aborted run.
